alu_request_arbiter: RTL and testbench
======================================

Name: alu_request_arbiter

Overview:
- Round-robin scheduler that shares one 16-bit ALU datapath (add/sub/and/or, op codes 000-011) among NREQ requesters.
- Per request: latches operands, drives the ALU, captures result and overflow, returns a done pulse to the winner.
- Publishes the last completed result to the seven-segment multiplexer via disp_value/disp_owner.
- Sits between requesting logic (switch-select front end, test sequencers) and the ALU and display blocks.

Parameters:
- NREQ, 4, number of requesters (2..8); index width IW = clog2(NREQ).
- WIDTH, 16, operand/result width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester request level.
- req_op  in  3*NREQ  packed op codes; requester i at [3i+2:3i].
- req_a  in  WIDTH*NREQ  packed operand A.
- req_b  in  WIDTH*NREQ  packed operand B.
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- done  out  NREQ  one-hot completion pulse, 1 cycle.
- rsp_result  out  WIDTH  result of last completed op.
- rsp_overflow  out  1  overflow of last completed op.
- busy  out  1  high whenever state != IDLE.
- alu_op  out  3  op code to ALU.
- alu_a  out  WIDTH  operand A to ALU.
- alu_b  out  WIDTH  operand B to ALU.
- alu_result  in  WIDTH  combinational ALU result.
- alu_overflow  in  1  combinational ALU overflow.
- disp_value  out  WIDTH  value shown on the 4-digit display.
- disp_owner  out  IW  requester that produced disp_value.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; state IDLE; round-robin pointer ptr=0.
  - Latched operands/op cleared; any in-flight op is discarded with no done.
- FSM: IDLE -> EXEC -> RESP -> IDLE. Fixed 3-cycle service; max throughput 1 op per 3 cycles.
- IDLE:
  - If req != 0, winner w = first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - Latch req_op/req_a/req_b of w into alu_op/alu_a/alu_b.
  - Register gnt[w]=1; next state EXEC.
  - If req == 0, stay in IDLE; alu_* hold previous values.
- EXEC (gnt high this cycle):
  - alu_* stable.
  - On the closing edge: rsp_result <= alu_result, rsp_overflow <= alu_overflow, disp_value <= alu_result, disp_owner <= w, done[w] <= 1, gnt <= 0.
  - Next state RESP.
- RESP (done high this cycle):
  - On the closing edge: done <= 0; ptr <= (w+1) mod NREQ; next state IDLE.
- Latency: req sampled at edge k -> gnt high cycle k+1 -> done high cycle k+2 with rsp_* valid -> a new grant no earlier than cycle k+4.
- Requester protocol:
  - Hold req, op and operands stable until gnt; drop req in the gnt cycle if no further op is wanted.
  - req still high in RESP is treated as a new request in the next IDLE.
  - req withdrawn before grant: ignored, no side effects.
  - Operand changes after the IDLE latch edge have no effect.
- Simultaneous requests: exactly one winner per IDLE visit; ptr rotation guarantees each continuously-asserted requester a grant within NREQ services.
- rsp_result, rsp_overflow, disp_value and disp_owner hold until the next completion.
- Op codes 1xx are forwarded unchanged; the result is whatever the ALU returns. See Optional Feature.

Optional Feature:
- Macro ALU_ARB_ILLEGAL_OP_EN.
- Defined:
  - Extra output rsp_err (1 bit, reset 0).
  - A winner with op[2]=1 still gets gnt and done at the normal cycles, but alu_* are not updated.
  - rsp_result=0, rsp_overflow=0, rsp_err=1; disp_value and disp_owner unchanged.
  - rsp_err=0 on every legal completion.
- Undefined: no rsp_err port; all op codes are forwarded to the ALU.

Test Plan:
- Reset, then req[0] with op 000, A=0x4321, B=0x0000 -> gnt[0] next cycle; done[0] one cycle later; rsp_result=0x4321, rsp_overflow=0, disp_value=0x4321, disp_owner=0.
- req[0] and req[2] asserted together after reset, each held until its own grant -> grants in order 0 then 2; done[2] 3 cycles after done[0]; ptr=3 afterwards.
- All four req held high for 12 services -> grant order 0,1,2,3,0,1,... with no requester skipped.
- req[1] op 000, A=0x7000, B=0x7000 (reference ALU model) -> rsp_result=0xE000, rsp_overflow=1. Then op 001, A=0x8000, B=0x0001 -> rsp_result=0x7FFF, rsp_overflow=1.
- rst pulsed low during EXEC -> all outputs 0 immediately, no done pulse, ptr=0; the next request from req[3] alone is served normally.
- With ALU_ARB_ILLEGAL_OP_EN defined, req[2] op 101 -> done[2] with rsp_err=1, rsp_result=0, disp_value unchanged. A following legal op gives rsp_err=0.

Source files
------------

// File: rtl/alu_request_arbiter_if.sv
// ============================================================================
//  Module      : alu_request_arbiter_if
//  Description : Requester-side bus of the ALU request arbiter. Requesters
//                present a request level, op code and operands per slot.
//                They receive one-hot grant/done pulses and the shared
//                response. rsp_err exists only when ALU_ARB_ILLEGAL_OP_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_request_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    logic [NREQ-1:0]       req;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_overflow;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic                  rsp_err;

    modport master (
        output req, req_op, req_a, req_b,
        input  gnt, done, rsp_result, rsp_overflow, rsp_err
    );

    modport slave (
        input  req, req_op, req_a, req_b,
        output gnt, done, rsp_result, rsp_overflow, rsp_err
    );
`else
    modport master (
        output req, req_op, req_a, req_b,
        input  gnt, done, rsp_result, rsp_overflow
    );

    modport slave (
        input  req, req_op, req_a, req_b,
        output gnt, done, rsp_result, rsp_overflow
    );
`endif
endinterface

`default_nettype wire

// File: rtl/alu_request_arbiter.sv
// ============================================================================
//  Module      : alu_request_arbiter
//  Description : Round-robin scheduler sharing one ALU among NREQ requesters.
//                IDLE latches the winner's op/operands and pulses gnt. EXEC
//                captures the ALU result and pulses done. RESP advances the
//                round-robin pointer. The last result is also published to
//                the display.
//                Optional macro ALU_ARB_ILLEGAL_OP_EN: ops with op[2]=1 are
//                not sent to the ALU and complete with rsp_err=1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_request_arbiter #(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 16,
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    alu_request_arbiter_if.slave    bus,
    output logic                    o_busy,
    output logic [2:0]              o_alu_op,
    output logic [WIDTH-1:0]        o_alu_a,
    output logic [WIDTH-1:0]        o_alu_b,
    input  wire logic [WIDTH-1:0]   i_alu_result,
    input  wire logic               i_alu_overflow,
    output logic [WIDTH-1:0]        o_disp_value,
    output logic [IW-1:0]           o_disp_owner
);

    localparam logic [1:0]      S_IDLE = 2'd0;
    localparam logic [1:0]      S_EXEC = 2'd1;
    localparam logic [1:0]      S_RESP = 2'd2;

    localparam logic [IW:0]     c_NREQ = (IW+1)'(NREQ);
    localparam logic [IW-1:0]   c_LAST = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_ONE  = NREQ'(1);

    logic [1:0]       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_win;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic [2:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_overflow;
    logic [WIDTH-1:0] r_disp_value;
    logic [IW-1:0]    r_disp_owner;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic             r_ill;
    logic             r_rsp_err;
`endif

    logic             w_found;
    logic [IW-1:0]    w_win;
    logic [IW:0]      w_sum;
    logic [IW-1:0]    w_cand;
    logic [2:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // Round-robin search: first asserted request starting at r_ptr, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= c_NREQ) begin
                w_sum = w_sum - c_NREQ;
            end
            w_cand = w_sum[IW-1:0];
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_sel_op = bus.req_op[3*w_win +: 3];
    assign w_sel_a  = bus.req_a[WIDTH*w_win +: WIDTH];
    assign w_sel_b  = bus.req_b[WIDTH*w_win +: WIDTH];

    // Three-phase service FSM: grant/latch, capture result, rotate pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_win          <= '0;
            r_gnt          <= '0;
            r_done         <= '0;
            r_alu_op       <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_disp_value   <= '0;
            r_disp_owner   <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            r_ill          <= 1'b0;
            r_rsp_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win   <= w_win;
                        r_gnt   <= c_ONE << w_win;
                        r_state <= S_EXEC;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                        // Illegal ops leave the ALU inputs untouched
                        r_ill   <= w_sel_op[2];
                        if (!w_sel_op[2]) begin
                            r_alu_op <= w_sel_op;
                            r_alu_a  <= w_sel_a;
                            r_alu_b  <= w_sel_b;
                        end
`else
                        r_alu_op <= w_sel_op;
                        r_alu_a  <= w_sel_a;
                        r_alu_b  <= w_sel_b;
`endif
                    end
                end
                S_EXEC: begin
                    r_gnt   <= '0;
                    r_done  <= c_ONE << r_win;
                    r_state <= S_RESP;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    if (r_ill) begin
                        r_rsp_result   <= '0;
                        r_rsp_overflow <= 1'b0;
                        r_rsp_err      <= 1'b1;
                    end else begin
                        r_rsp_result   <= i_alu_result;
                        r_rsp_overflow <= i_alu_overflow;
                        r_rsp_err      <= 1'b0;
                        r_disp_value   <= i_alu_result;
                        r_disp_owner   <= r_win;
                    end
`else
                    r_rsp_result   <= i_alu_result;
                    r_rsp_overflow <= i_alu_overflow;
                    r_disp_value   <= i_alu_result;
                    r_disp_owner   <= r_win;
`endif
                end
                S_RESP: begin
                    r_done  <= '0;
                    r_ptr   <= (r_win == c_LAST) ? '0 : r_win + 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = r_gnt;
    assign bus.done         = r_done;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_overflow = r_rsp_overflow;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign bus.rsp_err      = r_rsp_err;
`endif

    assign o_busy       = (r_state != S_IDLE);
    assign o_alu_op     = r_alu_op;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_disp_value = r_disp_value;
    assign o_disp_owner = r_disp_owner;

endmodule

`default_nettype wire

// File: tb/tb_alu_request_arbiter.sv
// ============================================================================
//  Module      : tb_alu_request_arbiter
//  Description : Directed self-checking bench for alu_request_arbiter with a
//                reference 16-bit add/sub/and/or ALU model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_request_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        w_busy;
    logic [2:0]  w_alu_op;
    logic [15:0] w_alu_a;
    logic [15:0] w_alu_b;
    logic [15:0] w_alu_result;
    logic        w_alu_overflow;
    logic [15:0] w_disp_value;
    logic [1:0]  w_disp_owner;

    int n_tests = 0;
    int n_fail  = 0;

    alu_request_arbiter_if #(.NREQ(4), .WIDTH(16)) u_bus ();

    alu_request_arbiter #(.NREQ(4), .WIDTH(16)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (u_bus),
        .o_busy         (w_busy),
        .o_alu_op       (w_alu_op),
        .o_alu_a        (w_alu_a),
        .o_alu_b        (w_alu_b),
        .i_alu_result   (w_alu_result),
        .i_alu_overflow (w_alu_overflow),
        .o_disp_value   (w_disp_value),
        .o_disp_owner   (w_disp_owner)
    );

    always #5 clk = ~clk;

    // Reference ALU: two's-complement add/sub with signed overflow, and, or
    always_comb begin
        w_alu_result   = '0;
        w_alu_overflow = 1'b0;
        case (w_alu_op)
            3'b000: begin
                w_alu_result   = w_alu_a + w_alu_b;
                w_alu_overflow = (w_alu_a[15] == w_alu_b[15]) && (w_alu_result[15] != w_alu_a[15]);
            end
            3'b001: begin
                w_alu_result   = w_alu_a - w_alu_b;
                w_alu_overflow = (w_alu_a[15] != w_alu_b[15]) && (w_alu_result[15] != w_alu_a[15]);
            end
            3'b010:  w_alu_result = w_alu_a & w_alu_b;
            3'b011:  w_alu_result = w_alu_a | w_alu_b;
            default: w_alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        u_bus.req[idx]           = 1'b1;
        u_bus.req_op[3*idx +: 3] = op;
        u_bus.req_a[16*idx +: 16] = a;
        u_bus.req_b[16*idx +: 16] = b;
    endtask

    task automatic do_reset();
        u_bus.req = '0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // One complete service of a lone requester, starting from IDLE
    task automatic serve(input string tag, input int idx, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic exp_ovf);
        set_req(idx, op, a, b);
        tick();
        chk({tag, "_gnt"}, 32'(u_bus.gnt), 32'(1) << idx);
        u_bus.req[idx] = 1'b0;
        tick();
        chk({tag, "_done"}, 32'(u_bus.done), 32'(1) << idx);
        chk({tag, "_res"},  32'(u_bus.rsp_result), 32'(exp_res));
        chk({tag, "_ovf"},  32'(u_bus.rsp_overflow), 32'(exp_ovf));
        tick();
    endtask

    // Bounded wait for the next grant, then compare against expected winner
    task automatic wait_gnt(input string tag, input int idx);
        int n;
        n = 0;
        tick();
        while (u_bus.gnt == '0 && n < 8) begin
            tick();
            n++;
        end
        chk(tag, 32'(u_bus.gnt), 32'(1) << idx);
    endtask

    initial begin
        int exp_w;
        int gap;
        u_bus.req    = '0;
        u_bus.req_op = '0;
        u_bus.req_a  = '0;
        u_bus.req_b  = '0;

        // Reset state
        tick();
        chk("rst_gnt",  32'(u_bus.gnt), 0);
        chk("rst_done", 32'(u_bus.done), 0);
        chk("rst_res",  32'(u_bus.rsp_result), 0);
        chk("rst_busy", 32'(w_busy), 0);
        chk("rst_alua", 32'(w_alu_a), 0);
        chk("rst_disp", 32'(w_disp_value), 0);
        rst = 1'b1;
        tick();

        // Single request, exact latency
        set_req(0, 3'b000, 16'h4321, 16'h0000);
        tick();
        chk("t1_gnt",   32'(u_bus.gnt), 32'h1);
        chk("t1_busy",  32'(w_busy), 1);
        chk("t1_alua",  32'(w_alu_a), 32'h4321);
        chk("t1_done0", 32'(u_bus.done), 0);
        u_bus.req[0] = 1'b0;
        tick();
        chk("t1_done",  32'(u_bus.done), 32'h1);
        chk("t1_gnt0",  32'(u_bus.gnt), 0);
        chk("t1_res",   32'(u_bus.rsp_result), 32'h4321);
        chk("t1_ovf",   32'(u_bus.rsp_overflow), 0);
        chk("t1_disp",  32'(w_disp_value), 32'h4321);
        chk("t1_own",   32'(w_disp_owner), 0);
        tick();
        chk("t1_idle",  32'(w_busy), 0);
        chk("t1_hold",  32'(u_bus.rsp_result), 32'h4321);

        // Two simultaneous requests: 0 then 2, done[2] three cycles after done[0]
        do_reset();
        set_req(0, 3'b000, 16'h0001, 16'h0002);
        set_req(2, 3'b011, 16'h00F0, 16'h0F00);
        tick();
        chk("t2_gnt0", 32'(u_bus.gnt), 32'h1);
        u_bus.req[0] = 1'b0;
        tick();
        chk("t2_done0", 32'(u_bus.done), 32'h1);
        chk("t2_res0",  32'(u_bus.rsp_result), 32'h3);
        gap = 0;
        tick();
        gap++;
        while (u_bus.done == '0 && gap < 8) begin
            if (u_bus.gnt[2]) u_bus.req[2] = 1'b0;
            tick();
            gap++;
        end
        chk("t2_gap",   32'(gap), 3);
        chk("t2_done2", 32'(u_bus.done), 32'h4);
        chk("t2_res2",  32'(u_bus.rsp_result), 32'h0FF0);
        chk("t2_own2",  32'(w_disp_owner), 2);
        u_bus.req[2] = 1'b0;
        tick();
        // Pointer now at 3: with 0 and 3 requesting, 3 must win
        set_req(0, 3'b000, 16'h0000, 16'h0000);
        set_req(3, 3'b000, 16'h0000, 16'h0000);
        tick();
        chk("t2_ptr3", 32'(u_bus.gnt), 32'h8);

        // All four held: strict rotation over 12 services
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'b000, 16'(i), 16'h0000);
        exp_w = 0;
        for (int s = 0; s < 12; s++) begin
            wait_gnt("t3_rr", exp_w);
            exp_w = (exp_w + 1) % 4;
        end

        // Overflow cases and logic ops through the reference ALU
        do_reset();
        serve("t4_add", 1, 3'b000, 16'h7000, 16'h7000, 16'hE000, 1'b1);
        chk("t4_disp", 32'(w_disp_value), 32'hE000);
        chk("t4_own",  32'(w_disp_owner), 1);
        serve("t4_sub", 1, 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
        serve("t4_and", 2, 3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
        serve("t4_or",  3, 3'b011, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0);

        // Asynchronous reset while EXEC: everything clears, no done, ptr=0
        do_reset();
        serve("t5_pre", 1, 3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0);
        set_req(2, 3'b000, 16'h1111, 16'h1111);
        tick();
        chk("t5_gnt", 32'(u_bus.gnt), 32'h4);
        rst = 1'b0;
        #1;
        chk("t5_gnt0",  32'(u_bus.gnt), 0);
        chk("t5_done0", 32'(u_bus.done), 0);
        chk("t5_res0",  32'(u_bus.rsp_result), 0);
        chk("t5_busy0", 32'(w_busy), 0);
        chk("t5_alua0", 32'(w_alu_a), 0);
        chk("t5_disp0", 32'(w_disp_value), 0);
        u_bus.req = '0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_nodone", 32'(u_bus.done), 0);
        end
        set_req(1, 3'b000, 16'h0000, 16'h0000);
        set_req(3, 3'b000, 16'h0000, 16'h0000);
        tick();
        chk("t5_ptr0", 32'(u_bus.gnt), 32'h2);
        u_bus.req = '0;
        tick();
        tick();
        serve("t5_r3", 3, 3'b001, 16'h0005, 16'h0003, 16'h0002, 1'b0);
        chk("t5_own3", 32'(w_disp_owner), 3);

`ifdef ALU_ARB_ILLEGAL_OP_EN
        // Illegal op: normal handshake, ALU untouched, error response
        set_req(2, 3'b101, 16'h1234, 16'h1111);
        tick();
        chk("t6_gnt",   32'(u_bus.gnt), 32'h4);
        chk("t6_alua",  32'(w_alu_a), 32'h0005);
        u_bus.req[2] = 1'b0;
        tick();
        chk("t6_done",  32'(u_bus.done), 32'h4);
        chk("t6_err",   32'(u_bus.rsp_err), 1);
        chk("t6_res",   32'(u_bus.rsp_result), 0);
        chk("t6_ovf",   32'(u_bus.rsp_overflow), 0);
        chk("t6_disp",  32'(w_disp_value), 32'h0002);
        chk("t6_own",   32'(w_disp_owner), 3);
        tick();
        serve("t6_leg", 2, 3'b011, 16'h00F0, 16'h000F, 16'h00FF, 1'b0);
        chk("t6_err0",  32'(u_bus.rsp_err), 0);
`else
        // Without the option, op codes 1xx are forwarded to the ALU unchanged
        set_req(2, 3'b100, 16'h1234, 16'h1111);
        tick();
        chk("t6_fwd_op", 32'(w_alu_op), 32'h4);
        chk("t6_fwd_a",  32'(w_alu_a), 32'h1234);
        u_bus.req[2] = 1'b0;
        tick();
        chk("t6_fwd_done", 32'(u_bus.done), 32'h4);
        chk("t6_fwd_own",  32'(w_disp_owner), 2);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
